// File: rtl/shortfifo_packetizer.sv
// shortfifo_packetizer: drains a shortfifo into framed packets on a valid/ready
// word stream. Each packet is a header {seq, n}, n payload words popped straight
// from the FIFO, and a trailer that makes all packet words sum to zero mod 2^dw.
// Optional partial-batch flush timer: define SHORTFIFO_PACKETIZER_TIMEOUT_EN.
module shortfifo_packetizer #(
  parameter int dw   = 8,
  parameter int aw   = 4,
  parameter int plen = 4,
  parameter int tw   = 12,
  localparam int lw  = $clog2(plen + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [dw-1:0]    fifo_dout,
  input  logic             fifo_empty,
  input  logic [aw-1:0]    fifo_count,
  output logic             fifo_re,
  input  logic [tw-1:0]    timeout,
  output logic [dw-1:0]    o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             o_ready,
  output logic [dw-lw-1:0] seq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_TRAILER
  } state_t;

  localparam logic [aw:0]   PLEN_OCC = (aw + 1)'(plen);
  localparam logic [lw-1:0] PLEN_N   = lw'(plen);

  state_t           r_state;
  state_t           w_nextState;
  logic [dw-lw-1:0] r_seq;
  logic [lw-1:0]    r_n;
  logic [lw-1:0]    r_rem;
  logic [dw-1:0]    r_sum;

  logic [aw:0]      w_occ;
  logic             w_full;
  logic             w_trigger;
  logic [lw-1:0]    w_nLatch;
  logic [dw-1:0]    w_header;
  logic [dw-1:0]    w_check;

  // FIFO count encodes occupancy-1 with all-ones meaning empty
  assign w_occ    = fifo_empty ? '0 : ({1'b0, fifo_count} + (aw + 1)'(1));
  assign w_full   = (w_occ >= PLEN_OCC);
  assign w_nLatch = w_full ? PLEN_N : w_occ[lw-1:0];
  assign w_header = {r_seq, r_n};
  assign w_check  = dw'(0) - r_sum;
  assign seq      = r_seq;

`ifdef SHORTFIFO_PACKETIZER_TIMEOUT_EN
  logic [tw-1:0] r_timer;
  logic          w_timeoutHit;

  assign w_timeoutHit = (timeout != '0) && (r_timer == timeout) && (w_occ != '0);
  assign w_trigger    = w_full || w_timeoutHit;

  // Age of a partial batch waiting in IDLE; saturates, cleared whenever not waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if ((r_state != S_IDLE) || (w_occ == '0) || w_full) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + tw'(1);
    end
  end
`else
  logic w_unusedTimeout;

  assign w_unusedTimeout = ^timeout;
  assign w_trigger       = w_full;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and stream outputs; outputs depend only on held state so they stay stable while stalled
  always_comb begin
    w_nextState = r_state;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    o_data      = '0;
    fifo_re     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_nextState = S_HEADER;
        end
      end
      S_HEADER: begin
        o_valid = 1'b1;
        o_data  = w_header;
        if (o_ready) begin
          w_nextState = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        o_valid = 1'b1;
        o_data  = fifo_dout;
        fifo_re = o_ready;
        if (o_ready && (r_rem == lw'(1))) begin
          w_nextState = S_TRAILER;
        end
      end
      S_TRAILER: begin
        o_valid = 1'b1;
        o_last  = 1'b1;
        o_data  = w_check;
        if (o_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Packet datapath: length latch, remaining-word counter, running checksum, sequence number
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= '0;
      r_sum <= '0;
      r_n   <= '0;
      r_rem <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_n   <= w_nLatch;
            r_rem <= w_nLatch;
            r_sum <= '0;
          end
        end
        S_HEADER: begin
          if (o_ready) begin
            r_sum <= r_sum + w_header;
          end
        end
        S_PAYLOAD: begin
          if (o_ready) begin
            r_sum <= r_sum + fifo_dout;
            r_rem <= r_rem - lw'(1);
          end
        end
        S_TRAILER: begin
          if (o_ready) begin
            r_seq <= r_seq + (dw - lw)'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shortfifo_packetizer.sv
// Testbench for shortfifo_packetizer with a behavioural shortfifo feeding it.
// Honours SHORTFIFO_PACKETIZER_TIMEOUT_EN to pick the timeout or no-flush scenario.
module tb_shortfifo_packetizer;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic [AW-1:0] fifo_count;
  logic          fifo_re;
  logic [TW-1:0] timeout;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic          o_ready;
  logic [4:0]    seq;

  logic          wrEn = 1'b0;
  logic [7:0]    wrData = '0;

  logic [7:0]    mem [16];
  logic [3:0]    wp = '0;
  logic [3:0]    rp = '0;
  logic [4:0]    cnt = '0;

  logic [7:0]    capData [$];
  logic          capLast [$];
  int            capCyc [$];
  int            cycleNo = 0;
  int            popCount = 0;
  int            stallErr = 0;
  int            reErr = 0;
  logic          prevStall = 1'b0;
  logic [7:0]    prevData = '0;
  logic          prevLast = 1'b0;

  logic [7:0]    payQ [$];
  logic [7:0]    expQ [$];
  logic          expLastQ [$];

  int            checkCount = 0;
  int            failCount = 0;

  always #5 clk = ~clk;

  shortfifo_packetizer dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_re    (fifo_re),
    .timeout    (timeout),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_ready    (o_ready),
    .seq        (seq)
  );

  // Behavioural shortfifo: combinational head, pop on fifo_re, no reset
  always @(posedge clk) begin
    if (wrEn) begin
      mem[wp] <= wrData;
      wp      <= wp + 4'd1;
    end
    if (fifo_re) begin
      rp <= rp + 4'd1;
    end
    cnt <= cnt + 5'(wrEn) - 5'(fifo_re);
  end

  assign fifo_empty = (cnt == 5'd0);
  assign fifo_count = (cnt == 5'd0) ? 4'hF : 4'(cnt - 5'd1);
  assign fifo_dout  = mem[rp];

  // Stream monitor: captures accepted words, counts pops, flags stall and pop-gating violations
  always @(negedge clk) begin
    cycleNo <= cycleNo + 1;
    if (o_valid && o_ready) begin
      capData.push_back(o_data);
      capLast.push_back(o_last);
      capCyc.push_back(cycleNo);
    end
    if (fifo_re) begin
      popCount <= popCount + 1;
      if (!(o_valid && o_ready) || (o_data != fifo_dout) || o_last) begin
        reErr <= reErr + 1;
      end
    end
    if (prevStall && (!o_valid || (o_data != prevData) || (o_last != prevLast))) begin
      stallErr <= stallErr + 1;
    end
    prevStall <= o_valid && !o_ready;
    prevData  <= o_data;
    prevLast  <= o_last;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    wrEn   = 1'b1;
    wrData = d;
    @(posedge clk);
    #1;
    wrEn   = 1'b0;
  endtask

  task automatic waitWords(input int target, input int budget);
    int k;
    k = 0;
    while ((capData.size() < target) && (k < budget)) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("wordsSeen", 32'(capData.size()), 32'(target));
  endtask

  // Reference packet: header {seq, n}, payload, two's-complement checksum
  task automatic modelPacket(input logic [4:0] s);
    logic [7:0] hdr;
    logic [7:0] sum;
    hdr = {s, 3'(payQ.size())};
    sum = hdr;
    expQ.push_back(hdr);
    expLastQ.push_back(1'b0);
    foreach (payQ[i]) begin
      expQ.push_back(payQ[i]);
      expLastQ.push_back(1'b0);
      sum = sum + payQ[i];
    end
    expQ.push_back(8'h00 - sum);
    expLastQ.push_back(1'b1);
    payQ.delete();
  endtask

  task automatic comparePacket(input string tag, input int base);
    logic [7:0] gotD;
    logic       gotL;
    foreach (expQ[i]) begin
      gotD = (base + i < capData.size()) ? capData[base + i] : 8'h00;
      gotL = (base + i < capLast.size()) ? capLast[base + i] : 1'b0;
      checkOutput({tag, "Data"}, 32'(gotD), 32'(expQ[i]));
      checkOutput({tag, "Last"}, 32'(gotL), 32'(expLastQ[i]));
    end
    expQ.delete();
    expLastQ.delete();
  endtask

  initial begin
    int base;
    int popBase;
    int seen;
    int k;
    logic [7:0]  t1Words [4];
    logic [7:0]  t1Exp [6];
    logic [15:0] readyPat;

    t1Words  = '{8'h11, 8'h22, 8'h33, 8'h44};
    t1Exp    = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h52};
    readyPat = 16'b1011_0010_1100_1010;

    rst     = 1'b1;
    o_ready = 1'b0;
    timeout = '0;
    tick(3);
    checkOutput("rstValid", 32'(o_valid), 32'd0);
    checkOutput("rstLast", 32'(o_last), 32'd0);
    checkOutput("rstData", 32'(o_data), 32'd0);
    checkOutput("rstRe", 32'(fifo_re), 32'd0);
    checkOutput("rstSeq", 32'(seq), 32'd0);

    $display("[TB] full packet, ready held high");
    rst     = 1'b0;
    o_ready = 1'b1;
    base    = capData.size();
    popBase = popCount;
    for (int i = 0; i < 4; i++) applyStimulus(t1Words[i]);
    waitWords(base + 6, 40);
    for (int i = 0; i < 6; i++) begin
      checkOutput("fullData", 32'((base + i < capData.size()) ? capData[base + i] : 8'h00), 32'(t1Exp[i]));
      checkOutput("fullLast", 32'((base + i < capLast.size()) ? capLast[base + i] : 1'b0), 32'(i == 5));
    end
    checkOutput("fullSpan", 32'((capCyc.size() >= base + 6) ? capCyc[base + 5] - capCyc[base] : 0), 32'd5);
    checkOutput("fullPops", 32'(popCount - popBase), 32'd4);
    checkOutput("fullSeq", 32'(seq), 32'd1);

    $display("[TB] backpressure");
    base    = capData.size();
    popBase = popCount;
    for (int i = 0; (i < 80) && (capData.size() < base + 6); i++) begin
      o_ready = readyPat[4'(i)];
      wrEn    = (i < 4);
      wrData  = t1Words[2'(i)];
      @(posedge clk);
      #1;
    end
    wrEn    = 1'b0;
    o_ready = 1'b1;
    tick(1);
    checkOutput("bpWords", 32'(capData.size()), 32'(base + 6));
    payQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    modelPacket(5'd1);
    comparePacket("bp", base);
    checkOutput("bpPops", 32'(popCount - popBase), 32'd4);
    checkOutput("bpStall", 32'(stallErr), 32'd0);
    checkOutput("bpReGate", 32'(reErr), 32'd0);
    checkOutput("bpSeq", 32'(seq), 32'd2);

`ifdef SHORTFIFO_PACKETIZER_TIMEOUT_EN
    $display("[TB] timeout flush");
    timeout = 12'd10;
    base    = capData.size();
    wrEn    = 1'b1;
    wrData  = 8'h01;
    @(posedge clk);
    #1;
    wrData  = 8'h02;
    @(negedge clk);
    checkOutput("toOcc", 32'(fifo_empty), 32'd0);
    k = 0;
    while (!o_valid && (k < 40)) begin
      @(negedge clk);
      k++;
      if (k == 1) wrEn = 1'b0;
    end
    checkOutput("toLatency", 32'(k), 32'd11);
    @(posedge clk);
    #1;
    waitWords(base + 4, 40);
    for (int i = 0; i < 4; i++) begin
      t1Words[i] = (i == 0) ? 8'h12 : (i == 1) ? 8'h01 : (i == 2) ? 8'h02 : 8'hEB;
      checkOutput("toData", 32'((base + i < capData.size()) ? capData[base + i] : 8'h00), 32'(t1Words[i]));
    end
    timeout = '0;
`else
    $display("[TB] partial batch without flush timer");
    timeout = 12'd10;
    base    = capData.size();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    tick(1000);
    checkOutput("noPartial", 32'(capData.size() - base), 32'd0);
    checkOutput("noPartialValid", 32'(o_valid), 32'd0);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    waitWords(base + 6, 40);
    t1Exp = '{8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE2};
    for (int i = 0; i < 6; i++) begin
      checkOutput("lateData", 32'((base + i < capData.size()) ? capData[base + i] : 8'h00), 32'(t1Exp[i]));
    end
    timeout = '0;
`endif
    checkOutput("seqAfterT3", 32'(seq), 32'd3);

    $display("[TB] overfill before ready");
    o_ready = 1'b0;
    base    = capData.size();
    for (int i = 0; i < 15; i++) applyStimulus(8'(8'h30 + i));
    checkOutput("ofCount", 32'(fifo_count), 32'hE);
    checkOutput("ofHdrValid", 32'(o_valid), 32'd1);
    checkOutput("ofHdrData", 32'(o_data), 32'h1C);
    o_ready = 1'b1;
    waitWords(base + 18, 150);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) payQ.push_back(8'(8'h30 + 4 * p + i));
      modelPacket(5'(3 + p));
    end
    comparePacket("of", base);
    tick(5);
    checkOutput("ofLeft", 32'(fifo_count), 32'd2);
    checkOutput("ofIdle", 32'(o_valid), 32'd0);
    checkOutput("ofStall", 32'(stallErr), 32'd0);

    $display("[TB] reset mid-payload");
    applyStimulus(8'h3F);
    seen = 0;
    k    = 0;
    while ((seen < 2) && (k < 40)) begin
      @(negedge clk);
      k++;
      if (fifo_re) seen++;
    end
    checkOutput("rePulses", 32'(seen), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mrValid", 32'(o_valid), 32'd0);
    checkOutput("mrSeq", 32'(seq), 32'd0);
    checkOutput("mrRe", 32'(fifo_re), 32'd0);
    checkOutput("mrCount", 32'(fifo_count), 32'd1);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = capData.size();
    applyStimulus(8'h50);
    applyStimulus(8'h60);
    waitWords(base + 6, 40);
    payQ = '{8'h3E, 8'h3F, 8'h50, 8'h60};
    modelPacket(5'd0);
    comparePacket("mr", base);

    $display("[TB] sequence wrap");
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checkOutput("wrapStart", 32'(seq), 32'd0);
    for (int p = 0; p < 32; p++) begin
      base = capData.size();
      for (int i = 0; i < 4; i++) begin
        payQ.push_back(8'(3 * p + i));
        applyStimulus(8'(3 * p + i));
      end
      modelPacket(5'(p));
      waitWords(base + 6, 40);
      comparePacket("wrap", base);
    end
    tick(2);
    checkOutput("wrapSeq", 32'(seq), 32'd0);
    checkOutput("endStall", 32'(stallErr), 32'd0);
    checkOutput("endReGate", 32'(reErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/shortfifo_packetizer.md
# shortfifo_packetizer

Drains a shortfifo (combinational `dout`, `re` pop, `count` with −1 = empty) and emits framed packets on a valid/ready word stream toward the board's link serializer. Each packet is a header word, 1..`plen` payload words taken straight from the FIFO, and a trailer checksum word. A packet starts when `plen` words are queued, or optionally when a partial batch has waited too long.

## Interface
- `dw`, 8: word width, FIFO and output stream.
- `aw`, 4: FIFO address width; must match the shortfifo instance.
- `plen`, 4: maximum payload words per packet, 1 ≤ plen ≤ 2^aw−1.
- `tw`, 12: timeout counter width.
- Derived `lw` = $clog2(plen+1), the length field width; requires dw ≥ lw+1.

- `clk`  in  1  single clock; everything is in this domain.
- `rst`  in  1  reset, synchronous, active-high.
- `fifo_dout`  in  dw  FIFO head word, valid whenever `fifo_empty` is low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_count`  in  aw  FIFO count; all-ones = empty, otherwise occupancy−1.
- `fifo_re`  out  1  pop strobe, combinational.
- `timeout`  in  tw  partial-flush timeout in cycles; 0 disables. Ignored without the macro.
- `o_data`  out  dw  stream word.
- `o_valid`  out  1  stream valid.
- `o_last`  out  1  marks the trailer word.
- `o_ready`  in  1  downstream accept.
- `seq`  out  dw−lw  sequence number of the next or current packet.

## Operation
- Occupancy `occ` is (aw+1) bits: 0 if `fifo_empty`, else `fifo_count`+1.
- FSM states: IDLE → HEADER → PAYLOAD → TRAILER → IDLE.
- IDLE:
  - The trigger condition is `occ` ≥ plen, or a timeout flush (see Configuration).
  - On the trigger, latch `n` = min(occ, plen) and clear `sum`, then go to HEADER.
- HEADER:
  - `o_data` = {seq, n}, with seq in the upper dw−lw bits and n in the lower lw bits.
  - On accept, `sum` += header and the FSM goes to PAYLOAD.
- PAYLOAD:
  - `o_data` = `fifo_dout` and `o_valid` = 1.
  - `fifo_re` = `o_valid` & `o_ready`.
  - Each accept adds the word to `sum` and decrements the remaining count. After n accepts the FSM goes to TRAILER.
  - The FIFO cannot run dry, since n ≤ occ at latch and the block is the only reader.
- TRAILER:
  - `o_data` = (−sum) mod 2^dw, so all packet words sum to 0 mod 2^dw.
  - `o_last` = 1.
  - On accept, `seq` increments (wrapping at 2^(dw−lw)) and the FSM returns to IDLE.
- Handshake rules:
  - A word transfers on a cycle with `o_valid` & `o_ready`.
  - Once `o_valid` rises it stays high until the packet's trailer is accepted.
  - `o_data` and `o_last` are stable while stalled.
- In IDLE: `o_valid` = 0, `o_last` = 0, `o_data` = 0.
- `fifo_re` is never asserted outside PAYLOAD.
- Concurrent FIFO writes during a packet are allowed and do not change `n`.

## Timing
- Reset values: state IDLE, `seq` 0, `sum` 0, timer 0. Outputs `o_valid` 0, `o_last` 0, `o_data` 0, `fifo_re` 0.
- Trigger observed in cycle t gives the header on `o_valid` at t+1.
- With `o_ready` held high, a packet occupies exactly n+2 consecutive cycles. The next trigger is evaluated in the first IDLE cycle after the trailer, so there is one idle cycle minimum between packets.
- Reset mid-packet:
  - The block goes to IDLE next cycle and `seq` returns to 0.
  - Words already popped are lost; unpopped words stay in the FIFO.
  - The FIFO itself has no reset.
- `occ` = 2^aw−1 (FIFO full) is legal and still yields n = plen.

## Configuration
- Macro `SHORTFIFO_PACKETIZER_TIMEOUT_EN`.
- Defined: a tw-bit timer runs in IDLE.
  - It increments each cycle 0 < occ < plen and saturates.
  - It is forced to 0 when occ = 0, occ ≥ plen, outside IDLE, or on reset.
  - When timer == `timeout` and `timeout` ≠ 0, the trigger fires with n = occ.
- Undefined: there is no timer logic, and `timeout` is unused. Only full packets are sent; partial data waits indefinitely.

## Test plan
- Full packet, defaults, `o_ready`=1, seq 0: write 0x11, 0x22, 0x33, 0x44 → stream 0x04, 0x11, 0x22, 0x33, 0x44, 0x52. `o_last` is set only on 0x52, `fifo_re` pulses 4 cycles, then `seq`=1.
- Backpressure: same data with `o_ready` toggling pseudo-randomly → identical word sequence. There are no pops while `o_ready`=0, and `o_data` holds steady during stalls.
- Timeout (macro defined), seq 1, `timeout`=10: write 0x01, 0x02, with occ first nonzero at cycle c → header 0x0A valid at c+11, then 0x01, 0x02, 0xF3. With the macro undefined, nothing is emitted for ≥1000 cycles.
- Overfill: 15 words written before `o_ready` rises → three 4-word packets with seq 0, 1, 2; 3 words remain with `fifo_count`=2.
- Reset mid-payload, after 2 pops of a 4-word packet → `o_valid`=0 next cycle and `seq`=0. The remaining 2 words plus 2 new ones produce a fresh packet with header 0x04.
- Sequence wrap: 32 full packets → header seq field runs 0..31, then returns to 0.
